// File: rtl/fish_sprite_engine.sv
// Fish sprite engine: per-fish motion FSMs, catch reporting, and a two-stage
// pixel overlay fed by an external synchronous sprite ROM.

// One fish channel: position/motion state plus its stage-1 hit test.
module fish_channel #(
    parameter int SPR_W      = 40,
    parameter int SPR_H      = 35,
    parameter int H_RES      = 640,
    parameter int SPEED      = 1,
    parameter int HOOK_SPEED = 2,
    parameter int SURFACE_Y  = 60,
    parameter int ADDR_W     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic              spawn_go,
    input  logic              spawn_dir,
    input  logic [9:0]        spawn_v,
    input  logic              hook_go,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    output logic              active,
    output logic              catch_evt,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);
    typedef enum logic [1:0] {IDLE, SWIM, HOOKED} state_t;

    localparam logic [10:0] H_END = 11'(H_RES + SPR_W);
    localparam logic [10:0] SPD   = 11'(SPEED);
    localparam logic [10:0] HSPD  = 11'(HOOK_SPEED);
    localparam logic [10:0] SURF  = 11'(SURFACE_Y);

    state_t      state, state_nx;
    logic [10:0] h_pos, h_nx, v_pos, v_nx;
    logic        dir, dir_nx;
    logic [10:0] h_ext, v_ext, col, row;
    logic        in_h, in_v;

    // State and position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            h_pos <= '0;
            v_pos <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_nx;
            h_pos <= h_nx;
            v_pos <= v_nx;
            dir   <= dir_nx;
        end
    end

    // Spawn / swim / hook transitions; hook beats a same-cycle frame_tick.
    always_comb begin
        state_nx  = state;
        h_nx      = h_pos;
        v_nx      = v_pos;
        dir_nx    = dir;
        catch_evt = 1'b0;
        case (state)
            IDLE: begin
                if (spawn_go) begin
                    state_nx = SWIM;
                    v_nx     = {1'b0, spawn_v};
                    dir_nx   = spawn_dir;
                    h_nx     = spawn_dir ? 11'd0 : H_END;
                end
            end
            SWIM: begin
                if (hook_go) begin
                    state_nx = HOOKED;
                end else if (frame_tick) begin
                    if (!dir) begin
                        h_nx = (h_pos > SPD) ? h_pos - SPD : 11'd0;
                        if (h_pos <= SPD) state_nx = IDLE;
                    end else begin
                        h_nx = h_pos + SPD;
                        if (h_pos + SPD >= H_END) state_nx = IDLE;
                    end
                end
            end
            HOOKED: begin
                if (frame_tick) begin
                    v_nx = (v_pos > HSPD) ? v_pos - HSPD : 11'd0;
                    if (v_nx <= SURF) begin
                        state_nx  = IDLE;
                        catch_evt = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sprite-box test and ROM address; dir=1 mirrors the column.
    always_comb begin
        h_ext  = {1'b0, h_cnt};
        v_ext  = {1'b0, v_cnt};
        active = (state != IDLE);
        in_h   = (h_ext + 11'(SPR_W) >= h_pos) && (h_ext < h_pos);
        in_v   = (v_ext >= v_pos) && (v_ext < v_pos + 11'(SPR_H));
        hit    = active && in_h && in_v;
        col    = dir ? (h_pos - h_ext - 11'd1) : (h_ext + 11'(SPR_W) - h_pos);
        row    = v_ext - v_pos;
        addr   = ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
    end
endmodule

module fish_sprite_engine #(
    parameter int          N_FISH     = 4,
    parameter int          IDW        = (N_FISH > 1) ? $clog2(N_FISH) : 1,
    parameter int          SPR_W      = 40,
    parameter int          SPR_H      = 35,
    parameter int          H_RES      = 640,
    parameter int          SPEED      = 1,
    parameter int          HOOK_SPEED = 2,
    parameter int          SURFACE_Y  = 60,
    parameter logic [11:0] KEY        = 12'h352,
    parameter int          ADDR_W     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pixel_en,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              frame_tick,
    input  logic              spawn_valid,
    output logic              spawn_ready,
    input  logic [IDW-1:0]    spawn_id,
    input  logic              spawn_dir,
    input  logic [9:0]        spawn_v,
    input  logic              hook_valid,
    input  logic [IDW-1:0]    hook_id,
    output logic              caught_pulse,
    output logic [IDW-1:0]    caught_id,
    output logic [N_FISH-1:0] fish_active,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic              background,
    output logic [11:0]       vga
);
    logic [N_FISH-1:0]             spawn_go, hook_go, catch_evt, hit;
    logic [N_FISH-1:0][ADDR_W-1:0] addr;
    logic [N_FISH-1:0]             pend, cand, low1;
    logic [IDW-1:0]                pick_id;
    logic                          sel_hit, hit1;
    logic [ADDR_W-1:0]             sel_addr;

    // Channel decode: ready follows the addressed channel's idle state.
    always_comb begin
        spawn_ready = 1'b0;
        for (int i = 0; i < N_FISH; i++)
            if (spawn_id == IDW'(i)) spawn_ready = !fish_active[i];
        for (int i = 0; i < N_FISH; i++) begin
            spawn_go[i] = spawn_valid && spawn_ready && (spawn_id == IDW'(i));
            hook_go[i]  = hook_valid && (hook_id == IDW'(i));
        end
    end

    for (genvar g = 0; g < N_FISH; g++) begin : g_ch
        fish_channel #(
            .SPR_W(SPR_W), .SPR_H(SPR_H), .H_RES(H_RES), .SPEED(SPEED),
            .HOOK_SPEED(HOOK_SPEED), .SURFACE_Y(SURFACE_Y), .ADDR_W(ADDR_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .frame_tick(frame_tick),
            .spawn_go  (spawn_go[g]),
            .spawn_dir (spawn_dir),
            .spawn_v   (spawn_v),
            .hook_go   (hook_go[g]),
            .h_cnt     (h_cnt),
            .v_cnt     (v_cnt),
            .active    (fish_active[g]),
            .catch_evt (catch_evt[g]),
            .hit       (hit[g]),
            .addr      (addr[g])
        );
    end

    // Lowest-id pending catch is reported first; the rest queue as bits.
    always_comb begin
        cand    = pend | catch_evt;
        low1    = cand & (~cand + 1'b1);
        pick_id = '0;
        for (int i = N_FISH - 1; i >= 0; i--)
            if (cand[i]) pick_id = IDW'(i);
    end

    // Catch report register: one id per clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend         <= '0;
            caught_pulse <= 1'b0;
            caught_id    <= '0;
        end else begin
            pend         <= cand & ~low1;
            caught_pulse <= |cand;
            if (|cand) caught_id <= pick_id;
        end
    end

    // Lowest-index hitting fish owns the pixel.
    always_comb begin
        sel_hit  = 1'b0;
        sel_addr = '0;
        for (int i = N_FISH - 1; i >= 0; i--)
            if (hit[i]) begin
                sel_hit  = 1'b1;
                sel_addr = addr[i];
            end
    end

    // Render stage 1: hit flag and ROM address (address holds on a miss).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit1     <= 1'b0;
            rom_addr <= '0;
        end else if (pixel_en) begin
            hit1 <= sel_hit;
            if (sel_hit) rom_addr <= sel_addr;
        end
    end

    // Render stage 2: colour-key test on the ROM word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            background <= 1'b1;
            vga        <= 12'h000;
        end else if (pixel_en) begin
            if (hit1 && rom_data != KEY) begin
                background <= 1'b0;
                vga        <= rom_data;
            end else begin
                background <= 1'b1;
                vga        <= 12'h000;
            end
        end
    end
endmodule

// File: tb/tb_fish_sprite_engine.sv
module tb_fish_sprite_engine;
    localparam int          NF  = 4;
    localparam logic [11:0] KEY = 12'h352;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pixel_en = 1'b0, frame_tick = 1'b0;
    logic [9:0]  h_cnt = '0, v_cnt = '0, spawn_v = '0;
    logic        spawn_valid = 1'b0, spawn_dir = 1'b0, hook_valid = 1'b0;
    logic [1:0]  spawn_id = '0, hook_id = '0;
    logic        spawn_ready, caught_pulse, background;
    logic [1:0]  caught_id;
    logic [3:0]  fish_active;
    logic [10:0] rom_addr;
    logic [11:0] rom_data = '0, vga;

    int n_chk = 0, n_err = 0;
    bit started = 0;

    // sprite ROM stimulus controls
    bit          force_en = 0;
    logic [11:0] force_val = '0;

    // behavioural model state
    int          m_st[NF], m_h[NF], m_v[NF], m_dir[NF];
    int          m_addr, m_cid;
    bit          m_hit1, m_bg, m_cp;
    logic [11:0] m_rom, m_vga;
    int          cq[$];

    fish_sprite_engine dut (
        .clk(clk), .rst_n(rst_n), .pixel_en(pixel_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .frame_tick(frame_tick), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawn_id(spawn_id), .spawn_dir(spawn_dir), .spawn_v(spawn_v),
        .hook_valid(hook_valid), .hook_id(hook_id), .caught_pulse(caught_pulse),
        .caught_id(caught_id), .fish_active(fish_active), .rom_addr(rom_addr),
        .rom_data(rom_data), .background(background), .vga(vga)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_fn(input int a);
        logic [11:0] x;
        if (force_en) return force_val;
        if (a % 5 == 0) return KEY;
        x = 12'((a * 7 + 1443) ^ (a << 3));
        if (x == KEY) x = x ^ 12'h001;
        return x;
    endfunction

    // external synchronous ROM
    always_ff @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            m_st[i] = 0; m_h[i] = 0; m_v[i] = 0; m_dir[i] = 0;
        end
        m_addr = 0; m_hit1 = 0; m_bg = 1; m_vga = '0; m_cp = 0; m_cid = 0;
        m_rom = rom_fn(0);
        cq.delete();
    endtask

    // Advance the model across one clock edge using the pre-edge inputs.
    task automatic model_update();
        int pre_addr = m_addr;
        if (pixel_en) begin
            bit found = 0;
            if (m_hit1 && m_rom != KEY) begin m_bg = 0; m_vga = m_rom; end
            else begin m_bg = 1; m_vga = '0; end
            for (int i = 0; i < NF; i++) begin
                int c = int'(h_cnt) + 40 - m_h[i];
                int r = int'(v_cnt) - m_v[i];
                if (!found && m_st[i] != 0 && c >= 0 && c < 40 && r >= 0 && r < 35) begin
                    found = 1;
                    m_addr = r * 40 + (m_dir[i] != 0 ? 39 - c : c);
                end
            end
            m_hit1 = found;
        end
        m_rom = rom_fn(pre_addr);
        for (int i = 0; i < NF; i++) begin
            if (m_st[i] == 0) begin
                if (spawn_valid && int'(spawn_id) == i) begin
                    m_st[i] = 1; m_v[i] = int'(spawn_v); m_dir[i] = int'(spawn_dir);
                    m_h[i] = spawn_dir ? 0 : 680;
                end
            end else if (m_st[i] == 1) begin
                if (hook_valid && int'(hook_id) == i) m_st[i] = 2;
                else if (frame_tick) begin
                    if (m_dir[i] == 0) begin
                        m_h[i] = (m_h[i] - 1 < 0) ? 0 : m_h[i] - 1;
                        if (m_h[i] == 0) m_st[i] = 0;
                    end else begin
                        m_h[i] = m_h[i] + 1;
                        if (m_h[i] >= 680) m_st[i] = 0;
                    end
                end
            end else if (frame_tick) begin
                m_v[i] = (m_v[i] - 2 < 0) ? 0 : m_v[i] - 2;
                if (m_v[i] <= 60) begin m_st[i] = 0; cq.push_back(i); end
            end
        end
        if (cq.size() > 0) begin m_cp = 1; m_cid = cq.pop_front(); end
        else m_cp = 0;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_update(); else model_reset();
        #1;
        spawn_valid = 0; hook_valid = 0; frame_tick = 0; pixel_en = 0;
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin frame_tick = 1; step(); step(); end
    endtask

    task automatic spawn(input int id, input bit d, input int v);
        spawn_valid = 1; spawn_id = 2'(id); spawn_dir = d; spawn_v = 10'(v);
        step();
    endtask

    task automatic hook(input int id);
        hook_valid = 1; hook_id = 2'(id);
        step();
    endtask

    task automatic pix(input int h, input int v);
        h_cnt = 10'(h); v_cnt = 10'(v); pixel_en = 1;
        step(); step();
    endtask

    // Compare DUT against the model every cycle, mid-cycle.
    initial forever begin
        @(negedge clk);
        if (started && rst_n) begin
            logic [3:0] ea;
            for (int i = 0; i < NF; i++) ea[i] = (m_st[i] != 0);
            chk("fish_active", int'(fish_active), int'(ea));
            chk("spawn_ready", int'(spawn_ready), int'(m_st[spawn_id] == 0));
            chk("caught_pulse", int'(caught_pulse), int'(m_cp));
            chk("caught_id", int'(caught_id), m_cid);
            chk("rom_addr", int'(rom_addr), m_addr);
            chk("background", int'(background), int'(m_bg));
            chk("vga", int'(vga), int'(m_vga));
        end
    end

    initial begin
        model_reset();
        rst_n = 0;
        repeat (3) step();
        chk("rst_active", int'(fish_active), 0);
        chk("rst_bg", int'(background), 1);
        chk("rst_vga", int'(vga), 0);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_caught", int'(caught_pulse), 0);
        rst_n = 1; started = 1;
        step();

        // swim right, then read a mirrored sprite pixel
        force_en = 1; force_val = 12'h9DD;
        spawn(0, 1, 100);
        chk("spawn_active", int'(fish_active), 1);
        do_tick(50);
        pix(20, 110);
        chk("addr_429", int'(rom_addr), 429);
        pix(20, 110);
        chk("opaque_bg", int'(background), 0);
        chk("opaque_vga", int'(vga), 12'h9DD);
        force_val = KEY; step();
        pix(20, 110);
        pix(20, 110);
        chk("key_bg", int'(background), 1);
        chk("key_vga", int'(vga), 0);

        // swim left off the screen edge
        spawn(1, 0, 300);
        do_tick(679);
        chk("left_alive", int'(fish_active[1]), 1);
        do_tick(1);
        chk("left_gone", int'(fish_active[1]), 0);

        // hook wins over a same-cycle tick, then reel to the surface
        spawn(2, 0, 70);
        hook_valid = 1; hook_id = 2; frame_tick = 1; step();
        pix(660, 70);
        chk("hook_no_move", int'(rom_addr), 20);
        do_tick(4);
        frame_tick = 1; step();
        chk("catch_pulse", int'(caught_pulse), 1);
        chk("catch_id", int'(caught_id), 2);
        chk("catch_idle", int'(fish_active[2]), 0);
        step();
        chk("catch_once", int'(caught_pulse), 0);

        // two catches in one cycle are reported in id order
        spawn(0, 1, 80);
        spawn(3, 1, 80);
        hook(0);
        hook(3);
        do_tick(9);
        frame_tick = 1; step();
        chk("dual_p0", int'(caught_pulse), 1);
        chk("dual_id0", int'(caught_id), 0);
        step();
        chk("dual_p1", int'(caught_pulse), 1);
        chk("dual_id1", int'(caught_id), 3);
        step();
        chk("dual_end", int'(caught_pulse), 0);

        // overlap priority and busy-channel spawn
        force_val = 12'h123;
        spawn(0, 1, 200);
        do_tick(10);
        spawn(1, 1, 205);
        do_tick(45);
        pix(30, 210);
        chk("overlap_addr", int'(rom_addr), 424);
        pix(30, 210);
        chk("overlap_vga", int'(vga), 12'h123);
        spawn_id = 1; #1;
        chk("busy_ready", int'(spawn_ready), 0);
        spawn(1, 0, 500);
        pix(30, 237);
        chk("busy_unchanged", int'(rom_addr), 1294);

        // randomized traffic against the model
        force_en = 0; step();
        for (int c = 0; c < 4000; c++) begin
            spawn_valid = ($urandom_range(0, 7) == 0);
            spawn_id    = 2'($urandom_range(0, 3));
            spawn_dir   = 1'($urandom_range(0, 1));
            spawn_v     = 10'($urandom_range(60, 200));
            hook_valid  = ($urandom_range(0, 15) == 0);
            hook_id     = 2'($urandom_range(0, 3));
            frame_tick  = ($urandom_range(0, 2) == 0);
            if (c % 2 == 0) begin
                pixel_en = ($urandom_range(0, 3) != 0);
                h_cnt    = 10'($urandom_range(0, 700));
                v_cnt    = 10'($urandom_range(50, 260));
            end
            step();
        end

        // asynchronous reset mid-swim
        rst_n = 0; step(); rst_n = 1; step();
        force_en = 1; force_val = 12'h0F0;
        spawn(0, 1, 100);
        do_tick(3);
        pix(1, 110);
        pix(1, 110);
        chk("pre_rst_bg", int'(background), 0);
        chk("pre_rst_vga", int'(vga), 12'h0F0);
        #2 rst_n = 0;
        #1;
        chk("async_active", int'(fish_active), 0);
        chk("async_bg", int'(background), 1);
        chk("async_vga", int'(vga), 0);
        model_reset();
        step(); step();
        rst_n = 1;
        step(); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
